// File: rtl/spi_master_ctrl_if.sv
// Bundle between the SPI initiator and its users: request/response handshake plus SPI pins.
// "master" is the controller's view, "slave" is the requester/board side.
interface spi_master_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  start, rw, addr, wdata, miso,
        output busy, done, rdata, sclk, cs_n, mosi
    );

    modport slave (
        output start, rw, addr, wdata, miso,
        input  busy, done, rdata, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI initiator: one start pulse becomes one {addr, rw, data} frame, MSB first.
// All SPI pins are registered so sclk/cs_n cannot glitch.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic clk,
    input logic reset,
    spi_master_ctrl_if.master bus
);

    localparam int unsigned FRAME_BITS = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic                    rw_q, rw_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    cs_n_q, cs_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   wfield;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        wfield  = bus.rw ? '0 : bus.wdata;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    tx_d    = {bus.addr, bus.rw, wfield};
                    rw_d    = bus.rw;
                    div_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_WIDTH-2:0], bus.miso};
                    state_d = StShift;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StShift: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next frame bit; zeros fill in behind.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = StHold;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[DATA_WIDTH-2:0], bus.miso};
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StHold: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = StDone;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StSetup) || (state_d == StShift) || (state_d == StHold);
        cs_n_d = ~busy_d;
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.mosi  = tx_q[FRAME_BITS-1];
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) with SPI memory slave models,
// a timing model derived from frame arithmetic, and directed transactions with literal checks.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_master_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) b4 ();
    spi_master_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) b1 ();

    spi_master_ctrl #(.CLK_DIV(4), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    spi_master_ctrl #(.CLK_DIV(1), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    logic [1:0] start;
    logic [1:0] rw;
    logic [6:0] addr  [2];
    logic [7:0] wdata [2];
    wire  [1:0] miso;

    assign b4.start = start[0];
    assign b4.rw    = rw[0];
    assign b4.addr  = addr[0];
    assign b4.wdata = wdata[0];
    assign b4.miso  = miso[0];
    assign b1.start = start[1];
    assign b1.rw    = rw[1];
    assign b1.addr  = addr[1];
    assign b1.wdata = wdata[1];
    assign b1.miso  = miso[1];

    wire [1:0] o_csn  = {b1.cs_n, b4.cs_n};
    wire [1:0] o_sclk = {b1.sclk, b4.sclk};
    wire [1:0] o_mosi = {b1.mosi, b4.mosi};
    wire [1:0] o_busy = {b1.busy, b4.busy};
    wire [1:0] o_done = {b1.done, b4.done};
    wire [7:0] o_rdata [2];
    assign o_rdata[0] = b4.rdata;
    assign o_rdata[1] = b1.rdata;

    logic [7:0] mem [2][128];

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Slave: samples mosi on sclk rise, drives the addressed byte after each fall from bit 7 on.
    for (genvar g = 0; g < 2; g++) begin : g_slv
        logic [15:0] sr         = '0;
        int          rises      = 0;
        logic [6:0]  saddr      = '0;
        logic        miso_r     = 1'b0;
        int          frames     = 0;
        logic [15:0] last_frame = '0;
        int          last_rises = 0;
        logic        csn_p      = 1'b1;
        logic        sclk_p     = 1'b0;

        always @(o_sclk[g] or o_csn[g]) begin
            if (o_csn[g] !== csn_p) begin
                if (o_csn[g] === 1'b0) begin
                    rises = 0;
                    sr    = '0;
                end else if (o_csn[g] === 1'b1 && csn_p === 1'b0) begin
                    frames++;
                    last_frame = sr;
                    last_rises = rises;
                    miso_r     = 1'b0;
                end
            end
            if (o_sclk[g] !== sclk_p && o_csn[g] === 1'b0) begin
                if (o_sclk[g] === 1'b1) begin
                    sr = {sr[14:0], o_mosi[g]};
                    rises++;
                    if (rises == 8) saddr = sr[7:1];
                end else if (sclk_p === 1'b1 && rises >= 8 && rises < 16) begin
                    miso_r = mem[g][saddr][15 - rises];
                end
            end
            csn_p  = o_csn[g];
            sclk_p = o_sclk[g];
        end

        assign miso[g] = miso_r;
    end

    // Reference model: position k (cycles since acceptance) fully determines the pins.
    int          cyc = 0;
    bit          act    [2];
    int          k      [2];
    logic [15:0] mtx    [2];
    logic        mrw    [2];
    logic [6:0]  maddr  [2];
    logic [7:0]  mrdata [2];

    function automatic int hdiv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [4:0] model_pins(input bit a, input int kk, input int h,
                                              input logic [15:0] tx);
        int j, b;
        logic cs, sc, mo, bz, dn;
        cs = 1'b1; sc = 1'b0; mo = 1'b0; bz = 1'b0; dn = 1'b0;
        if (a) begin
            j = kk - h - 1;
            if (kk <= 34 * h) begin
                cs = 1'b0;
                bz = 1'b1;
            end
            dn = (kk == 34 * h + 1);
            if (j >= 0 && j < 32 * h) sc = ((j % (2 * h)) < h);
            if (kk <= h) begin
                mo = tx[15];
            end else if (j < 32 * h) begin
                b = (j + h) / (2 * h);
                if (b < 16) mo = tx[15 - b];
            end
        end
        return {cs, sc, mo, bz, dn};
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int h;
            h = hdiv(i);
            if (reset) begin
                act[i]    = 1'b0;
                k[i]      = 0;
                mrdata[i] = 8'h00;
            end else if (act[i]) begin
                if (k[i] == 34 * h + 1) begin
                    act[i] = 1'b0;
                end else begin
                    k[i]++;
                    if (k[i] == 34 * h + 1 && mrw[i]) mrdata[i] = mem[i][maddr[i]];
                end
            end else if (start[i]) begin
                act[i]   = 1'b1;
                k[i]     = 1;
                mrw[i]   = rw[i];
                maddr[i] = addr[i];
                mtx[i]   = {addr[i], rw[i], rw[i] ? 8'h00 : wdata[i]};
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                logic [4:0] e;
                e = model_pins(act[i], k[i], hdiv(i), mtx[i]);
                chk($sformatf("d%0d cyc%0d cs_n", i, cyc), o_csn[i], e[4]);
                chk($sformatf("d%0d cyc%0d sclk", i, cyc), o_sclk[i], e[3]);
                chk($sformatf("d%0d cyc%0d mosi", i, cyc), o_mosi[i], e[2]);
                chk($sformatf("d%0d cyc%0d busy", i, cyc), o_busy[i], e[1]);
                chk($sformatf("d%0d cyc%0d done", i, cyc), o_done[i], e[0]);
                chk($sformatf("d%0d cyc%0d rdata", i, cyc), o_rdata[i], mrdata[i]);
            end
        end
    end

    task automatic run_txn(input int i, input logic r, input logic [6:0] a, input logic [7:0] d,
                           input bit scramble, output int lat, output int low,
                           output logic [7:0] rd, output logic bz);
        @(negedge clk);
        start[i] = 1'b1;
        rw[i]    = r;
        addr[i]  = a;
        wdata[i] = d;
        @(negedge clk);
        start[i] = 1'b0;
        lat = 1;
        low = 0;
        while (1) begin
            if (o_csn[i] == 1'b0) low++;
            if (o_done[i] || lat >= 2000) break;
            if (scramble) begin
                addr[i]  = 7'($urandom);
                wdata[i] = 8'($urandom);
                rw[i]    = 1'($urandom);
                start[i] = (lat < 100) ? 1'($urandom) : 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start[i] = 1'b0;
        rd = o_rdata[i];
        bz = o_busy[i];
        chk($sformatf("d%0d done seen", i), o_done[i], 1'b1);
    endtask

    int         lat, low, f0, n, gap;
    logic [7:0] rd;
    logic       bz;

    initial begin
        for (int g = 0; g < 2; g++) begin
            for (int a = 0; a < 128; a++) mem[g][a] = 8'(a * 7 + g);
        end
        mem[0][7'h15] = 8'h3C;
        mem[1][7'h2A] = 8'h81;
        reset = 1'b1;
        start = '0;
        rw    = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end

        @(negedge clk);
        chk("reset cs_n", o_csn[0], 1'b1);
        chk("reset sclk", o_sclk[0], 1'b0);
        chk("reset mosi", o_mosi[0], 1'b0);
        chk("reset busy", o_busy[0], 1'b0);
        chk("reset done", o_done[0], 1'b0);
        chk("reset rdata", o_rdata[0], 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Write 0xA5 to 0x15
        run_txn(0, 1'b0, 7'h15, 8'hA5, 1'b0, lat, low, rd, bz);
        chk("write latency", lat, 137);
        chk("write cs_n low cycles", low, 136);
        chk("write frame", g_slv[0].last_frame, 16'h2AA5);
        chk("write rises", g_slv[0].last_rises, 16);
        chk("write rdata", rd, 8'h00);

        // Read 0x15 -> 0x3C
        run_txn(0, 1'b1, 7'h15, 8'hEE, 1'b0, lat, low, rd, bz);
        chk("read frame", g_slv[0].last_frame, 16'h2B00);
        chk("read rdata", rd, 8'h3C);
        chk("read busy at done", bz, 1'b0);
        chk("read latency", lat, 137);

        // Back-to-back with start held high throughout
        f0 = g_slv[0].frames;
        @(negedge clk);
        start[0] = 1'b1;
        rw[0]    = 1'b0;
        addr[0]  = 7'h01;
        wdata[0] = 8'h5A;
        @(negedge clk);
        wdata[0] = 8'hC3;
        n = 0;
        while (!o_done[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first done", o_done[0], 1'b1);
        chk("b2b first frame", g_slv[0].last_frame, 16'h025A);
        gap = 0;
        @(negedge clk);
        while (o_csn[0] && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        chk("b2b idle gap", gap, 1);
        n = 0;
        while (!o_done[0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        start[0] = 1'b0;
        chk("b2b second done", o_done[0], 1'b1);
        repeat (10) @(negedge clk);
        chk("b2b frame count", g_slv[0].frames - f0, 2);
        chk("b2b second frame", g_slv[0].last_frame, 16'h02C3);

        // Reset after the 5th sclk rise
        @(negedge clk);
        start[0] = 1'b1;
        rw[0]    = 1'b0;
        addr[0]  = 7'h33;
        wdata[0] = 8'h11;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (g_slv[0].rises < 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort reached rise 5", g_slv[0].rises, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort cs_n", o_csn[0], 1'b1);
        chk("abort sclk", o_sclk[0], 1'b0);
        chk("abort busy", o_busy[0], 1'b0);
        chk("abort done", o_done[0], 1'b0);
        chk("abort rdata cleared", o_rdata[0], 8'h00);
        chk("abort rises", g_slv[0].last_rises, 5);
        repeat (20) @(negedge clk);
        run_txn(0, 1'b0, 7'h7F, 8'hFF, 1'b0, lat, low, rd, bz);
        chk("post-abort latency", lat, 137);
        chk("post-abort frame", g_slv[0].last_frame, 16'hFEFF);

        // CLK_DIV=1 read
        run_txn(1, 1'b1, 7'h2A, 8'h77, 1'b0, lat, low, rd, bz);
        chk("div1 latency", lat, 35);
        chk("div1 rdata", rd, 8'h81);
        chk("div1 rises", g_slv[1].last_rises, 16);
        chk("div1 frame", g_slv[1].last_frame, 16'h5500);

        // Inputs scrambled every cycle while busy
        f0 = g_slv[0].frames;
        run_txn(0, 1'b0, 7'h4C, 8'h96, 1'b1, lat, low, rd, bz);
        chk("stable frame", g_slv[0].last_frame, 16'h9896);
        chk("stable latency", lat, 137);
        repeat (10) @(negedge clk);
        chk("stable frame count", g_slv[0].frames - f0, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
